// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, one Booth group per cycle.
// Operands are widened by two bits so that unsigned values and the most negative signed value multiply exactly.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;
  localparam int N  = EW / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [AW-1:0]      acc_q;
  logic [AW-1:0]      xs_q;
  logic [EW:0]        mplr_q;
  logic [2*WIDTH-1:0] result_q;
  logic               busy_q;
  logic               done_q;

  logic [EW-1:0]      a_ext;
  logic [EW-1:0]      b_ext;
  logic [AW-1:0]      pp;
  logic [AW-1:0]      acc_sum;

  assign a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  // xs_q already carries the 2i shift; mplr_q[2:0] is the current group {b[2i+1], b[2i], b[2i-1]}.
  always_comb begin
    // NOTE: default assignment first so every path drives pp and no latch is inferred.
    pp = '0;
    case (mplr_q[2:0])
      3'b001, 3'b010: pp = xs_q;
      3'b011:         pp = xs_q << 1;
      3'b100:         pp = ~(xs_q << 1) + AW'(1);
      3'b101, 3'b110: pp = ~xs_q + AW'(1);
      default:        pp = '0;
    endcase
  end

  assign acc_sum = acc_q + pp;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      xs_q     <= '0;
      mplr_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            xs_q    <= {{(AW-EW){a_ext[EW-1]}}, a_ext};
            mplr_q  <= {b_ext, 1'b0};
            acc_q   <= '0;
            cnt_q   <= CW'(N);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q  <= acc_sum;
          xs_q   <= xs_q << 2;
          mplr_q <= mplr_q >> 2;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= acc_sum[2*WIDTH-1:0];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed 32-bit corner cases, start/reset protocol,
// and a randomized 8-bit sweep against an arithmetic reference product.
module tb_booth_mul_seq;

  logic        clk;
  logic        resetn;

  logic        s32_start, s32_mode, s32_busy, s32_done;
  logic [31:0] s32_a, s32_b;
  logic [63:0] s32_res;

  logic        s8_start, s8_mode, s8_busy, s8_done;
  logic [7:0]  s8_a, s8_b;
  logic [15:0] s8_res;

  int n_checks = 0;
  int n_fail   = 0;

  booth_mul_seq #(.WIDTH(32)) dut32 (
    .clk        (clk),
    .resetn     (resetn),
    .start      (s32_start),
    .signed_mode(s32_mode),
    .a          (s32_a),
    .b          (s32_b),
    .busy       (s32_busy),
    .done       (s32_done),
    .result     (s32_res)
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .resetn     (resetn),
    .start      (s8_start),
    .signed_mode(s8_mode),
    .a          (s8_a),
    .b          (s8_b),
    .busy       (s8_busy),
    .done       (s8_done),
    .result     (s8_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Exact product of two w-bit operands, truncated to 2w bits.
  function automatic logic [63:0] ref_prod(input logic [31:0] av, input logic [31:0] bv,
                                           input logic m, input int w);
    logic [63:0] mask_in, mask_out, ua, ub, sbit;
    longint      sa, sb;
    mask_in  = (64'd1 << w) - 64'd1;
    mask_out = (64'd1 << (2 * w)) - 64'd1;
    ua = {32'd0, av} & mask_in;
    ub = {32'd0, bv} & mask_in;
    if (m) begin
      sbit = 64'd1 << (w - 1);
      sa   = longint'(ua ^ sbit) - longint'(sbit);
      sb   = longint'(ub ^ sbit) - longint'(sbit);
      return 64'(sa * sb) & mask_out;
    end
    return (ua * ub) & mask_out;
  endfunction

  // Edges after the current one until done is seen; 40 means it never came.
  task automatic wait_done32(output int edges);
    edges = 0;
    while (!s32_done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic wait_done8(output int edges);
    edges = 0;
    while (!s8_done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // Called 1ns after a rising edge. Latency is counted to the edge that samples done high.
  task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic m,
                      input logic [63:0] exp, input string tag);
    int edges;
    s32_a = av; s32_b = bv; s32_mode = m; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    s32_a = $urandom; s32_b = $urandom; s32_mode = ~m;
    check({tag, "_busy"}, 64'(s32_busy), 64'd1);
    wait_done32(edges);
    check({tag, "_lat"}, 64'(edges + 1), 64'd18);
    check({tag, "_res"}, s32_res, exp);
    check({tag, "_busy_at_done"}, 64'(s32_busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(s32_done), 64'd0);
    check({tag, "_hold"}, s32_res, exp);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic m, input int idx);
    int          edges;
    logic [63:0] exp;
    exp = ref_prod({24'd0, av}, {24'd0, bv}, m, 8);
    s8_a = av; s8_b = bv; s8_mode = m; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    s8_a = 8'($urandom); s8_b = 8'($urandom);
    wait_done8(edges);
    check($sformatf("w8_lat_%0d", idx), 64'(edges + 1), 64'd6);
    check($sformatf("w8_res_%0d_%h_%h_%0d", idx, av, bv, m), 64'(s8_res), exp);
    @(posedge clk); #1;
    check($sformatf("w8_pulse_%0d", idx), 64'(s8_done), 64'd0);
  endtask

  initial begin
    int          edges, total, dones;
    logic [31:0] ra, rb;
    logic        rm;
    logic [7:0]  ea, eb;

    resetn = 1'b0;
    s32_start = 1'b0; s32_mode = 1'b0; s32_a = '0; s32_b = '0;
    s8_start  = 1'b0; s8_mode  = 1'b0; s8_a  = '0; s8_b  = '0;

    #1;
    check("rst_busy",   64'(s32_busy), 64'd0);
    check("rst_done",   64'(s32_done), 64'd0);
    check("rst_result", s32_res,       64'd0);
    check("rst_busy8",  64'(s8_busy),  64'd0);

    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s_m1xm1");
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max");
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minxmin");
    op32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, "s_minxmax");
    op32(32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0, "zero_a");
    op32(32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 64'h0, "zero_b");
    op32(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s_7xm3");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rm = 1'($urandom);
      op32(ra, rb, rm, ref_prod(ra, rb, rm, 32), $sformatf("r32_%0d", i));
    end

    // Start during CALC is ignored; start in the DONE cycle is accepted back-to-back.
    s32_a = 32'd7; s32_b = 32'd6; s32_mode = 1'b1; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    total = 0;
    repeat (3) begin @(posedge clk); #1; total++; end
    s32_a = 32'd3; s32_b = 32'd3; s32_start = 1'b1;
    @(posedge clk); #1; total++;
    s32_start = 1'b0;
    check("ign_busy", 64'(s32_busy), 64'd1);
    wait_done32(edges);
    check("ign_lat", 64'(total + edges + 1), 64'd18);
    check("ign_res", s32_res, 64'd42);
    s32_a = 32'd3; s32_b = 32'd3; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    check("b2b_busy", 64'(s32_busy), 64'd1);
    check("b2b_done", 64'(s32_done), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_hold", s32_res, 64'd42);
    wait_done32(edges);
    check("b2b_lat", 64'(edges + 5), 64'd18);
    check("b2b_res", s32_res, 64'd9);
    @(posedge clk); #1;

    // Reset in the middle of CALC abandons the operation.
    s32_a = 32'd5; s32_b = 32'd7; s32_mode = 1'b0; s32_start = 1'b1;
    @(posedge clk); #1;
    s32_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_busy",   64'(s32_busy), 64'd0);
    check("mid_rst_done",   64'(s32_done), 64'd0);
    check("mid_rst_result", s32_res,       64'd0);
    #1;
    resetn = 1'b1;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (s32_done) dones++;
    end
    check("mid_rst_no_done", 64'(dones), 64'd0);
    check("mid_rst_res_kept", s32_res, 64'd0);
    op32(32'd1000, 32'd1000, 1'b0, 64'd1000000, "after_rst");

    // WIDTH=8 sweep: fixed corners first, then random operands in both modes.
    for (int i = 0; i < 8; i++) begin
      ea = (i[0]) ? 8'h80 : 8'hFF;
      eb = (i[1]) ? 8'h7F : 8'h00;
      op8(ea, eb, i[2], i);
    end
    for (int i = 8; i < 3000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
